// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// One multiplier/quotient bit per cycle: shift-add multiply, restoring divide.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_con_Start,
    input  logic [2:0]       i_con_MdOp,
    input  logic [WIDTH-1:0] i_data_A,
    input  logic [WIDTH-1:0] i_data_B,
    output logic             o_con_Busy,
    output logic             o_con_Done,
    output logic [WIDTH-1:0] o_data_Hi,
    output logic [WIDTH-1:0] o_data_Lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;     // upper: partial product / remainder, lower: multiplier / quotient
    logic [WIDTH-1:0]   opnd;    // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   a_orig;
    logic               is_div, neg_q, neg_r;
    logic [WIDTH-1:0]   hi, lo;
    logic               busy, done;

    logic               op_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix;

    always_comb begin
        op_signed = ~i_con_MdOp[0];
        a_neg     = op_signed & i_data_A[WIDTH-1];
        b_neg     = op_signed & i_data_B[WIDTH-1];
        a_mag     = a_neg ? -i_data_A : i_data_A;
        b_mag     = b_neg ? -i_data_B : i_data_B;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opnd};
        prod_fix  = neg_q ? -acc : acc;
        q_fix     = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        r_fix     = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            a_orig <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_con_Start) begin
                        if (i_con_MdOp[2] == 1'b0) begin
                            state  <= RUN;
                            busy   <= 1'b1;
                            cnt    <= '0;
                            is_div <= i_con_MdOp[1];
                            neg_q  <= a_neg ^ b_neg;
                            neg_r  <= a_neg;
                            a_orig <= i_data_A;
                            // Multiply shifts the multiplier (A) out of the low half;
                            // divide shifts the dividend (A) out of the low half.
                            acc    <= {{WIDTH{1'b0}}, a_mag};
                            opnd   <= b_mag;
                        end else if (i_con_MdOp == 3'd4) begin
                            hi <= i_data_A;
                        end else if (i_con_MdOp == 3'd5) begin
                            lo <= i_data_A;
                        end
                    end
                end
                RUN: begin
                    if (is_div)
                        acc <= {div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0],
                                acc[WIDTH-2:0], ~div_diff[WIDTH]};
                    else
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    if (cnt == CW'(WIDTH-1))
                        state <= FIX;
                    else
                        cnt <= cnt + 1'b1;
                end
                FIX: begin
                    if (!is_div) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else if (opnd == '0) begin
                        hi <= a_orig;
                        lo <= '1;
                    end else begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_con_Busy = busy;
    assign o_con_Done = done;
    assign o_data_Hi  = hi;
    assign o_data_Lo  = lo;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: mult/div results, edge cases, start gating, async reset.
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;
    int          checks = 0;
    int          failures = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_con_Start(start), .i_con_MdOp(op),
        .i_data_A(a), .i_data_B(b), .o_con_Busy(busy), .o_con_Done(done),
        .o_data_Hi(hi), .o_data_Lo(lo)
    );

    always #5 clk = ~clk;

    // Issue one request (E0), then sample on negedges until Done or timeout.
    task automatic run_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                          output int busy_cyc, output bit got_done, output bit hl_moved);
        logic [31:0] hi0, lo0;
        @(negedge clk);
        hi0 = hi; lo0 = lo;
        start = 1'b1; op = o; a = va; b = vb;
        @(posedge clk); #1;
        start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
        busy_cyc = 0; got_done = 0; hl_moved = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin got_done = 1; break; end
            if (busy) busy_cyc++;
            if (hi !== hi0 || lo !== lo0) hl_moved = 1;
        end
    endtask

    task automatic test_reset;
        #12;
        checks++; if ({busy, done, hi, lo} !== 66'd0) begin failures++;
            $display("FAIL reset_state got busy=%b done=%b hi=%h lo=%h want all zero", busy, done, hi, lo); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_mult;
        int bc; bit gd, mv;
        run_op(3'd0, 32'hFFFF_FFFD, 32'd7, bc, gd, mv);
        checks++; if (!gd || bc != 33) begin failures++;
            $display("FAIL mult_timing got done=%0d busy_cycles=%0d want 1/33", gd, bc); end
        checks++; if (mv) begin failures++; $display("FAIL mult_hilo_stable got moved while busy want unchanged"); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mult_busy_in_done got %b want 0", busy); end
        checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin failures++;
            $display("FAIL mult_neg got hi=%h lo=%h want ffffffff/ffffffeb", hi, lo); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++;
            $display("FAIL done_one_cycle got done=%b busy=%b want 0/0", done, busy); end
    endtask

    task automatic test_mult_signs;
        int bc; bit gd, mv;
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, gd, mv);
        checks++; if (!gd || hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin failures++;
            $display("FAIL multu_max got hi=%h lo=%h want fffffffe/00000001", hi, lo); end
        @(negedge clk);
        run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, gd, mv);
        checks++; if (!gd || hi !== 32'h0 || lo !== 32'h1) begin failures++;
            $display("FAIL mult_m1_m1 got hi=%h lo=%h want 0/1", hi, lo); end
        @(negedge clk);
    endtask

    task automatic test_div;
        int bc; bit gd, mv;
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, bc, gd, mv);
        checks++; if (!gd || bc != 33 || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin failures++;
            $display("FAIL div_neg got busy=%0d hi=%h lo=%h want 33 ffffffff/fffffffd", bc, hi, lo); end
        @(negedge clk);
        run_op(3'd3, 32'd100, 32'd7, bc, gd, mv);
        checks++; if (!gd || lo !== 32'd14 || hi !== 32'd2) begin failures++;
            $display("FAIL divu_100_7 got hi=%h lo=%h want 2/14", hi, lo); end
        @(negedge clk);
    endtask

    task automatic test_div_edges;
        int bc; bit gd, mv;
        run_op(3'd3, 32'h1234, 32'd0, bc, gd, mv);
        checks++; if (!gd || bc != 33 || lo !== 32'hFFFF_FFFF || hi !== 32'h1234) begin failures++;
            $display("FAIL divu_by_zero got busy=%0d hi=%h lo=%h want 33 1234/ffffffff", bc, hi, lo); end
        @(negedge clk);
        run_op(3'd2, 32'hFFFF_FF00, 32'd0, bc, gd, mv);
        checks++; if (!gd || lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FF00) begin failures++;
            $display("FAIL div_by_zero_neg got hi=%h lo=%h want ffffff00/ffffffff", hi, lo); end
        @(negedge clk);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, bc, gd, mv);
        checks++; if (!gd || lo !== 32'h8000_0000 || hi !== 32'h0) begin failures++;
            $display("FAIL div_overflow got hi=%h lo=%h want 0/80000000", hi, lo); end
        @(negedge clk);
    endtask

    task automatic test_start_ignored;
        bit gd = 0;
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd5;
        @(posedge clk); #1 start = 1'b0;             // E0
        repeat (9) @(posedge clk);                    // E1..E9
        @(negedge clk);
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd3;
        @(posedge clk); #1 start = 1'b0;             // E10, must be ignored
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin gd = 1; break; end
        end
        checks++; if (!gd || hi !== 32'd0 || lo !== 32'd25) begin failures++;
            $display("FAIL start_ignored got done=%0d hi=%h lo=%h want 1 0/19", gd, hi, lo); end
        @(negedge clk);                               // after E34: idle
        start = 1'b1; op = 3'd4; a = 32'hAA;
        @(posedge clk); #1 start = 1'b0;
        checks++; if (hi !== 32'hAA || lo !== 32'd25 || busy !== 1'b0) begin failures++;
            $display("FAIL mthi got hi=%h lo=%h busy=%b want aa/19 0", hi, lo, busy); end
        @(negedge clk);
        start = 1'b1; op = 3'd5; a = 32'h55;
        @(posedge clk); #1 start = 1'b0;
        checks++; if (lo !== 32'h55 || hi !== 32'hAA || busy !== 1'b0 || done !== 1'b0) begin failures++;
            $display("FAIL mtlo got hi=%h lo=%h busy=%b done=%b want aa/55 0 0", hi, lo, busy, done); end
        @(negedge clk);
        start = 1'b1; op = 3'd6; a = 32'h77;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        checks++; if (lo !== 32'h55 || hi !== 32'hAA || busy !== 1'b0 || done !== 1'b0) begin failures++;
            $display("FAIL reserved_op got hi=%h lo=%h busy=%b done=%b want aa/55 0 0", hi, lo, busy, done); end
    endtask

    task automatic test_reset_mid;
        int bc; bit gd, mv;
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = 32'd9; b = 32'd9;
        @(posedge clk); #1 start = 1'b0;             // E0
        repeat (15) @(posedge clk);                   // counter now 15
        #2 rst = 1'b1;
        #1;
        checks++; if ({busy, done, hi, lo} !== 66'd0) begin failures++;
            $display("FAIL async_reset got busy=%b done=%b hi=%h lo=%h want all zero", busy, done, hi, lo); end
        @(negedge clk); rst = 1'b0;
        run_op(3'd0, 32'd2, 32'd3, bc, gd, mv);
        checks++; if (!gd || bc != 33 || lo !== 32'd6 || hi !== 32'd0) begin failures++;
            $display("FAIL mult_after_reset got busy=%0d hi=%h lo=%h want 33 0/6", bc, hi, lo); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_mult_signs();
        test_div();
        test_div_edges();
        test_start_ignored();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
